// File: rtl/interrupt_controller_if.sv
// CPU-side register bus and interrupt handshake for interrupt_controller.
// The master modport is the CPU/decoder side and the slave modport is the controller side.
interface interrupt_controller_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  ce;
    logic                  rw;
    logic [3:0]            address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  irq;
    logic                  ack;

    modport master (
        output ce, rw, address, data_in, ack,
        input  data_out, irq
    );

    modport slave (
        input  ce, rw, address, data_in, ack,
        output data_out, irq
    );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller with mask, arbiter and an IDLE/REQ/SERVICE handshake.
// Defining INTC_ROUND_ROBIN_EN replaces fixed lowest-index priority with rotating priority.
module interrupt_controller #(
    parameter int NUM_SOURCES  = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irq_source,
    interrupt_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_MASK    = 4'h0;
    localparam logic [3:0] ADDR_PENDING = 4'h1;
    localparam logic [3:0] ADDR_VECTOR  = 4'h2;
    localparam logic [3:0] ADDR_STATUS  = 4'h3;
    localparam logic [3:0] ADDR_EOI     = 4'h4;

    state_t                  state_q, state_d;
    logic [NUM_SOURCES-1:0]  mask_q, mask_d;
    logic [NUM_SOURCES-1:0]  pending_q, pending_d;
    logic [NUM_SOURCES-1:0]  prev_src_q;
    logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
    logic                    irq_q, irq_d;

    logic [NUM_SOURCES-1:0]  edge_det;
    logic [NUM_SOURCES-1:0]  req_vec;
    logic [NUM_SOURCES-1:0]  vec_onehot;
    logic [VECTOR_WIDTH-1:0] winner;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    wr_en;
    logic                    rd_en;
    logic                    eoi_wr;
    logic                    grant_ack;
    logic                    unused_bits;

`ifdef INTC_ROUND_ROBIN_EN
    logic [VECTOR_WIDTH-1:0] last_grant_q, last_grant_d;
`endif

    assign wr_en     = bus.ce & bus.rw;
    assign rd_en     = bus.ce & ~bus.rw;
    assign eoi_wr    = wr_en && (bus.address == ADDR_EOI);
    assign grant_ack = (state_q == ST_REQ) && bus.ack;
    assign edge_det  = irq_source & ~prev_src_q;
    assign req_vec   = pending_q & mask_q;

    // Only the low NUM_SOURCES bits of write data are meaningful.
    assign unused_bits = &{1'b0, bus.data_in};

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_onehot
        assign vec_onehot[gi] = (vector_q == VECTOR_WIDTH'(gi));
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (bus.address == ADDR_MASK)) begin
            mask_d = bus.data_in[NUM_SOURCES-1:0];
        end
    end

    // Clears are applied first so a same-cycle edge always re-sets its bit.
    always_comb begin
        pending_d = pending_q;
        if (wr_en && (bus.address == ADDR_PENDING)) begin
            pending_d = pending_d & ~bus.data_in[NUM_SOURCES-1:0];
        end
        if (grant_ack) begin
            pending_d = pending_d & ~vec_onehot;
        end
        pending_d = pending_d | edge_det;
    end

`ifdef INTC_ROUND_ROBIN_EN
    // Pick the requester with the smallest rotational distance from last_grant+1.
    always_comb begin
        int start;
        int dist;
        int best;
        winner = '0;
        best   = NUM_SOURCES;
        start  = int'(last_grant_q) + 1;
        if (start >= NUM_SOURCES) begin
            start = 0;
        end
        for (int j = 0; j < NUM_SOURCES; j++) begin
            dist = (j >= start) ? (j - start) : (j + NUM_SOURCES - start);
            if (req_vec[j] && (dist < best)) begin
                best   = dist;
                winner = VECTOR_WIDTH'(j);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int j = NUM_SOURCES - 1; j >= 0; j--) begin
            if (req_vec[j]) begin
                winner = VECTOR_WIDTH'(j);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        irq_d    = 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    vector_d = winner;
                    irq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once committed, the request stays up until the CPU acknowledges it.
                if (bus.ack) begin
                    state_d = ST_SERVICE;
`ifdef INTC_ROUND_ROBIN_EN
                    last_grant_d = vector_q;
`endif
                end else begin
                    irq_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            pending_q  <= '0;
            prev_src_q <= '0;
            vector_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            prev_src_q <= irq_source;
            vector_q   <= vector_d;
            irq_q      <= irq_d;
        end
    end

`ifdef INTC_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= VECTOR_WIDTH'(NUM_SOURCES - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (bus.address)
                ADDR_MASK:    rd_data[NUM_SOURCES-1:0]  = mask_q;
                ADDR_PENDING: rd_data[NUM_SOURCES-1:0]  = pending_q;
                ADDR_VECTOR:  rd_data[VECTOR_WIDTH-1:0] = vector_q;
                ADDR_STATUS: begin
                    rd_data[1:0] = state_q;
                    rd_data[2]   = irq_q;
`ifdef INTC_ROUND_ROBIN_EN
                    rd_data[8 +: VECTOR_WIDTH] = last_grant_q;
`endif
                end
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.data_out = rd_data;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a per-cycle vector table followed by
// hand-written sequences for asynchronous reset, ack in IDLE and chip-enable gating.
module tb_interrupt_controller;

    localparam logic [3:0] A_MASK = 4'h0;
    localparam logic [3:0] A_PEND = 4'h1;
    localparam logic [3:0] A_VEC  = 4'h2;
    localparam logic [3:0] A_STAT = 4'h3;
    localparam logic [3:0] A_EOI  = 4'h4;
    localparam logic [3:0] A_NONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] irq_source = '0;

    int errors = 0;
    int checks = 0;

    interrupt_controller_if #(.DATA_WIDTH(32)) bus_if ();

    interrupt_controller #(
        .NUM_SOURCES (16),
        .DATA_WIDTH  (32),
        .VECTOR_WIDTH(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_source(irq_source),
        .bus       (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ce;
        logic        rw;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [15:0] src;
        logic        ack;
        logic [3:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic ce, logic rw, logic [3:0] a, logic [31:0] d,
                                logic [15:0] s, logic ack, logic [3:0] ra, logic [31:0] er,
                                logic ei);
        vec_t v;
        v.name = n; v.ce = ce; v.rw = rw; v.addr = a; v.wdata = d;
        v.src = s; v.ack = ack; v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Drive one clock cycle of inputs, then return just after the rising edge.
    task automatic cycle(logic ce, logic rw, logic [3:0] a, logic [31:0] d,
                         logic [15:0] s, logic ack);
        bus_if.ce      = ce;
        bus_if.rw      = rw;
        bus_if.address = a;
        bus_if.data_in = d;
        bus_if.ack     = ack;
        irq_source     = s;
        @(posedge clk);
        #1;
        bus_if.ce  = 1'b0;
        bus_if.rw  = 1'b0;
        bus_if.ack = 1'b0;
    endtask

    task automatic rd(logic [3:0] a, output logic [31:0] v);
        bus_if.ce      = 1'b1;
        bus_if.rw      = 1'b0;
        bus_if.address = a;
        #1;
        v = bus_if.data_out;
        bus_if.ce = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;

        // name, ce, rw, addr, wdata, src, ack, read addr, expected read, expected irq
        vecs.push_back(mk("t1 mask=3",        1, 1, A_MASK, 32'h3,  16'h0000, 0, A_MASK, 32'h3,  0));
        vecs.push_back(mk("t1 edge src1",     0, 0, A_MASK, 32'h0,  16'h0002, 0, A_PEND, 32'h2,  0));
        vecs.push_back(mk("t1 irq vec1",      0, 0, A_MASK, 32'h0,  16'h0000, 0, A_VEC,  32'h1,  1));
        vecs.push_back(mk("t1 ack status",    0, 0, A_MASK, 32'h0,  16'h0000, 1, A_STAT, 32'h2,  0));
        vecs.push_back(mk("t1 eoi reads 0",   0, 0, A_MASK, 32'h0,  16'h0000, 0, A_EOI,  32'h0,  0));
        vecs.push_back(mk("t1 pend clr",      0, 0, A_MASK, 32'h0,  16'h0000, 0, A_PEND, 32'h0,  0));
        vecs.push_back(mk("t1 eoi idle",      1, 1, A_EOI,  32'h0,  16'h0000, 0, A_STAT, 32'h0,  0));
        vecs.push_back(mk("t2 edges 0,1",     0, 0, A_MASK, 32'h0,  16'h0003, 0, A_PEND, 32'h3,  0));
        vecs.push_back(mk("t2 first vec0",    0, 0, A_MASK, 32'h0,  16'h0000, 0, A_VEC,  32'h0,  1));
        vecs.push_back(mk("t2 ack pend",      0, 0, A_MASK, 32'h0,  16'h0000, 1, A_PEND, 32'h2,  0));
        vecs.push_back(mk("t2 eoi",           1, 1, A_EOI,  32'h5A, 16'h0000, 0, A_STAT, 32'h0,  0));
        vecs.push_back(mk("t2 second vec1",   0, 0, A_MASK, 32'h0,  16'h0000, 0, A_VEC,  32'h1,  1));
        vecs.push_back(mk("t2 ack2",          0, 0, A_MASK, 32'h0,  16'h0000, 1, A_STAT, 32'h2,  0));
        vecs.push_back(mk("t2 eoi2",          1, 1, A_EOI,  32'h0,  16'h0000, 0, A_STAT, 32'h0,  0));
        vecs.push_back(mk("t3 mask=0",        1, 1, A_MASK, 32'h0,  16'h0000, 0, A_MASK, 32'h0,  0));
        vecs.push_back(mk("t3 edge src5",     0, 0, A_MASK, 32'h0,  16'h0020, 0, A_PEND, 32'h20, 0));
        vecs.push_back(mk("t3 masked wait",   0, 0, A_MASK, 32'h0,  16'h0020, 0, A_NONE, 32'h0,  0));
        vecs.push_back(mk("t3 unmask",        1, 1, A_MASK, 32'h20, 16'h0020, 0, A_MASK, 32'h20, 0));
        vecs.push_back(mk("t3 irq vec5",      0, 0, A_MASK, 32'h0,  16'h0020, 0, A_VEC,  32'h5,  1));
        vecs.push_back(mk("t4 mask0 in req",  1, 1, A_MASK, 32'h0,  16'h0020, 0, A_STAT, 32'h5,  1));
        vecs.push_back(mk("t4 w1c in req",    1, 1, A_PEND, 32'h20, 16'h0020, 0, A_PEND, 32'h0,  1));
        vecs.push_back(mk("t4 eoi ignored",   1, 1, A_EOI,  32'h0,  16'h0020, 0, A_STAT, 32'h5,  1));
        vecs.push_back(mk("t4 ack",           0, 0, A_MASK, 32'h0,  16'h0020, 1, A_STAT, 32'h2,  0));
        vecs.push_back(mk("t4 eoi",           1, 1, A_EOI,  32'h0,  16'h0020, 0, A_STAT, 32'h0,  0));
        vecs.push_back(mk("t5 edge src3",     0, 0, A_MASK, 32'h0,  16'h0008, 0, A_PEND, 32'h8,  0));
        vecs.push_back(mk("t5 src3 low",      0, 0, A_MASK, 32'h0,  16'h0000, 0, A_PEND, 32'h8,  0));
        vecs.push_back(mk("t5 w1c+edge",      1, 1, A_PEND, 32'h8,  16'h0008, 0, A_PEND, 32'h8,  0));
        vecs.push_back(mk("t5 w1c alone",     1, 1, A_PEND, 32'h8,  16'h0008, 0, A_PEND, 32'h0,  0));
        vecs.push_back(mk("t6 mask=6",        1, 1, A_MASK, 32'h6,  16'h0000, 0, A_MASK, 32'h6,  0));
        vecs.push_back(mk("t6 edges 1,2",     0, 0, A_MASK, 32'h0,  16'h0006, 0, A_PEND, 32'h6,  0));
        vecs.push_back(mk("t6 irq vec1",      0, 0, A_MASK, 32'h0,  16'h0000, 0, A_VEC,  32'h1,  1));
        vecs.push_back(mk("t6 ack service",   0, 0, A_MASK, 32'h0,  16'h0000, 1, A_STAT, 32'h2,  0));
        vecs.push_back(mk("t6 re-edge src1",  0, 0, A_MASK, 32'h0,  16'h0002, 0, A_PEND, 32'h6,  0));

        bus_if.ce = 1'b0; bus_if.rw = 1'b0; bus_if.address = '0;
        bus_if.data_in = '0; bus_if.ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset irq", {31'd0, bus_if.irq}, 32'h0);
        rd(A_MASK, v); check("reset mask", v, 32'h0);
        rd(A_PEND, v); check("reset pending", v, 32'h0);
        rd(A_STAT, v); check("reset status", v, 32'h0);
        rd(A_VEC,  v); check("reset vector", v, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].ce, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].src, vecs[i].ack);
            rd(vecs[i].raddr, v);
            check(vecs[i].name, v, vecs[i].exp_rd);
            check({vecs[i].name, " irq"}, {31'd0, bus_if.irq}, {31'd0, vecs[i].exp_irq});
        end

        // Asynchronous reset while in SERVICE with PENDING=0x6.
        #2;
        rst = 1'b1;
        #1;
        check("async rst irq", {31'd0, bus_if.irq}, 32'h0);
        rd(A_PEND, v); check("async rst pending", v, 32'h0);
        rd(A_MASK, v); check("async rst mask", v, 32'h0);
        rd(A_STAT, v); check("async rst status", v, 32'h0);
        irq_source = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        cycle(1, 1, A_MASK, 32'h1, 16'h0000, 0);
        rd(A_MASK, v); check("resume mask=1", v, 32'h1);
        cycle(0, 0, A_MASK, 32'h0, 16'h0000, 1);
        rd(A_STAT, v); check("ack in idle ignored", v, 32'h0);
        cycle(0, 0, A_MASK, 32'h0, 16'h0001, 0);
        rd(A_PEND, v); check("resume edge src0", v, 32'h1);
        check("resume no irq yet", {31'd0, bus_if.irq}, 32'h0);
        cycle(0, 0, A_MASK, 32'h0, 16'h0000, 0);
        check("resume irq", {31'd0, bus_if.irq}, 32'h1);
        rd(A_VEC, v); check("resume vector0", v, 32'h0);

        bus_if.ce = 1'b0; bus_if.rw = 1'b0; bus_if.address = A_MASK;
        #1;
        check("read with ce=0", bus_if.data_out, 32'h0);

        cycle(0, 0, A_MASK, 32'h0, 16'h0000, 1);
        rd(A_STAT, v); check("resume ack", v, 32'h2);
        cycle(1, 1, A_EOI, 32'h0, 16'h0000, 0);
        rd(A_STAT, v); check("resume eoi", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
